// File: rtl/uio_gpio_pkg.sv
// Shared constants for the uio GPIO bank: register address map and address width.
package uio_gpio_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PIN      = 3'd5;

endpackage

// File: rtl/uio_sync.sv
// Multi-flop input synchroniser, one chain per bit, cleared by synchronous reset.
module uio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uio_gpio_bank.sv
// Bidirectional GPIO bank: direction/output registers, synchronised inputs,
// per-bit edge capture into sticky W1C status, and a masked interrupt.
module uio_gpio_bank
  import uio_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  pad_in,
  output logic [WIDTH-1:0]  pad_out,
  output logic [WIDTH-1:0]  pad_oe,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              irq
);

  localparam int                CNT_W     = 3;
  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] dir_r, out_r, mask_r, edge_sel_r, status_r, prev_r;
  logic [WIDTH-1:0] sync, rise, fall, hit, clear, rd_mux;
  logic [CNT_W-1:0] warm_cnt;
  logic             warm_done;

  uio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_in),
    .q   (sync)
  );

  // Warm-up hides the first 0->1 seen on pins that were already high at reset.
  assign warm_done = (warm_cnt == '0);
  assign rise      = sync & ~prev_r;
  assign fall      = ~sync & prev_r;
  assign hit       = ((edge_sel_r & fall) | (~edge_sel_r & rise)) & ~dir_r & {WIDTH{warm_done}};
  assign clear     = (wr_en && addr == ADDR_STATUS) ? wr_data : '0;

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DIR:      rd_mux = dir_r;
      ADDR_OUT:      rd_mux = out_r;
      ADDR_MASK:     rd_mux = mask_r;
      ADDR_EDGE_SEL: rd_mux = edge_sel_r;
      ADDR_STATUS:   rd_mux = status_r;
      ADDR_PIN:      rd_mux = sync;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r      <= '0;
      out_r      <= '0;
      mask_r     <= '0;
      edge_sel_r <= '0;
      status_r   <= '0;
      prev_r     <= '0;
      warm_cnt   <= WARM_LOAD;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_DIR:      dir_r      <= wr_data;
          ADDR_OUT:      out_r      <= wr_data;
          ADDR_MASK:     mask_r     <= wr_data;
          ADDR_EDGE_SEL: edge_sel_r <= wr_data;
          default:       ;
        endcase
      end
      // A fresh hit outranks a simultaneous clear of the same bit.
      status_r <= (status_r & ~clear) | hit;
      prev_r   <= sync;
      if (!warm_done) warm_cnt <= warm_cnt - 1'b1;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

  assign pad_oe  = dir_r;
  assign pad_out = out_r;
  assign irq     = |(status_r & mask_r);

endmodule

// File: tb/tb_uio_gpio_bank.sv
// Directed bench for uio_gpio_bank with a sample-history reference model checked every cycle.
module tb_uio_gpio_bank;
  import uio_gpio_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, rd_valid, irq;
  logic [W-1:0]  pad_in, pad_out, pad_oe, wr_data, rd_data;
  logic [2:0]    addr;

  int vectors = 0;
  int errors  = 0;

  uio_gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .pad_in   (pad_in),
    .pad_out  (pad_out),
    .pad_oe   (pad_oe),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin samples per edge since reset, plus edge count for warm-up.
  logic [W-1:0] m_dir, m_out, m_mask, m_esel, m_status, m_rd_data;
  logic         m_rd_valid;
  int           m_n;
  logic [W-1:0] hist [$];
  bit           started = 0;

  function automatic logic [W-1:0] hist_at(input int i);
    return (i < hist.size()) ? hist[i] : '0;
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] s, p, hit, clr;
    started = 1;
    if (rst) begin
      m_dir = '0; m_out = '0; m_mask = '0; m_esel = '0; m_status = '0;
      m_rd_data = '0; m_rd_valid = 1'b0; m_n = 0;
      hist.delete();
    end else begin
      s   = hist_at(S-1);
      p   = hist_at(S);
      hit = '0;
      for (int i = 0; i < W; i++)
        if (!m_dir[i] && m_n >= S + 1)
          hit[i] = m_esel[i] ? (!s[i] && p[i]) : (s[i] && !p[i]);
      m_rd_valid = rd_en;
      if (rd_en) begin
        case (addr)
          3'd0: m_rd_data = m_dir;
          3'd1: m_rd_data = m_out;
          3'd2: m_rd_data = m_mask;
          3'd3: m_rd_data = m_esel;
          3'd4: m_rd_data = m_status;
          3'd5: m_rd_data = s;
          default: m_rd_data = '0;
        endcase
      end
      clr = '0;
      if (wr_en) begin
        case (addr)
          3'd0: m_dir  = wr_data;
          3'd1: m_out  = wr_data;
          3'd2: m_mask = wr_data;
          3'd3: m_esel = wr_data;
          3'd4: clr    = wr_data;
          default: ;
        endcase
      end
      m_status = (m_status & ~clr) | hit;
      hist.push_front(pad_in);
      if (hist.size() > S + 1) hist.delete(hist.size() - 1);
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("pad_oe",   pad_oe,       m_dir);
      check("pad_out",  pad_out,      m_out);
      check("irq",      W'(irq),      W'(|(m_status & m_mask)));
      check("rd_valid", W'(rd_valid), W'(m_rd_valid));
      check("rd_data",  rd_data,      m_rd_data);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [W-1:0] exp);
    rd_en = 1'b1; addr = a;
    cyc(1);
    rd_en = 1'b0;
    check({name, "_valid"}, W'(rd_valid), 8'h01);
    check(name, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; pad_in = 8'hFF; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    cyc(3);
    rst = 1'b0;
    cyc(10);
    check("rst_pad_oe",  pad_oe,  8'h00);
    check("rst_pad_out", pad_out, 8'h00);
    check("rst_irq",     W'(irq), 8'h00);
    rd_chk("rst_status", ADDR_STATUS, 8'h00);
    rd_chk("rst_pin",    ADDR_PIN,    8'hFF);

    wr(ADDR_DIR, 8'hF0);
    check("dir_pad_oe", pad_oe, 8'hF0);
    wr(ADDR_OUT, 8'hA5);
    check("out_pad_out", pad_out, 8'hA5);
    rd_chk("rb_dir", ADDR_DIR, 8'hF0);
    rd_chk("rb_out", ADDR_OUT, 8'hA5);
    rd_chk("rb_unmapped", 3'd7, 8'h00);
    cyc(1);
    check("rd_valid_drop", W'(rd_valid), 8'h00);

    wr(ADDR_DIR, 8'h00);
    wr(ADDR_MASK, 8'h01);
    pad_in = 8'h00;
    cyc(4);
    rd_chk("no_fall_capture", ADDR_STATUS, 8'h00);
    pad_in = 8'h01;
    cyc(2);
    check("rise_irq_early", W'(irq), 8'h00);
    cyc(1);
    check("rise_irq", W'(irq), 8'h01);
    rd_chk("rise_status", ADDR_STATUS, 8'h01);
    wr(ADDR_STATUS, 8'h01);
    check("w1c_irq", W'(irq), 8'h00);

    wr(ADDR_EDGE_SEL, 8'h02);
    wr(ADDR_MASK, 8'h00);
    pad_in = 8'h03;
    cyc(4);
    pad_in = 8'h01;
    cyc(4);
    rd_chk("fall_status", ADDR_STATUS, 8'h02);
    check("fall_masked_irq", W'(irq), 8'h00);
    wr(ADDR_MASK, 8'h02);
    check("fall_unmask_irq", W'(irq), 8'h01);
    pad_in = 8'h03;
    cyc(4);
    rd_chk("fall_no_rise", ADDR_STATUS, 8'h02);
    wr(ADDR_STATUS, 8'hFF);
    wr(ADDR_EDGE_SEL, 8'h00);
    wr(ADDR_MASK, 8'h00);

    pad_in = 8'h07;
    cyc(2);
    wr(ADDR_STATUS, 8'h04);
    rd_chk("collision_status", ADDR_STATUS, 8'h04);
    wr(ADDR_STATUS, 8'h04);
    rd_chk("collision_clear", ADDR_STATUS, 8'h00);

    wr(ADDR_DIR, 8'h08);
    wr(ADDR_MASK, 8'h08);
    pad_in = 8'h0F;
    cyc(4);
    pad_in = 8'h07;
    cyc(4);
    rd_chk("outbit_status", ADDR_STATUS, 8'h00);
    check("outbit_irq", W'(irq), 8'h00);

    wr(ADDR_OUT, 8'h3C);
    rd_en = 1'b1; addr = ADDR_OUT; rst = 1'b1;
    cyc(1);
    rst = 1'b0; rd_en = 1'b0;
    cyc(1);
    check("midrst_rd_valid", W'(rd_valid), 8'h00);
    check("midrst_pad_oe",   pad_oe,       8'h00);
    check("midrst_pad_out",  pad_out,      8'h00);
    rd_chk("midrst_dir",    ADDR_DIR,      8'h00);
    rd_chk("midrst_mask",   ADDR_MASK,     8'h00);
    rd_chk("midrst_esel",   ADDR_EDGE_SEL, 8'h00);
    rd_chk("midrst_status", ADDR_STATUS,   8'h00);
    rd_chk("midrst_data",   ADDR_OUT,      8'h00);

    for (int i = 0; i < 300; i++) begin
      pad_in  = W'($urandom);
      wr_en   = ($urandom_range(0, 2) == 0);
      rd_en   = ($urandom_range(0, 1) == 1);
      addr    = 3'($urandom_range(0, 7));
      wr_data = W'($urandom);
      rst     = ($urandom_range(0, 60) == 0);
      cyc(1);
    end
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
    cyc(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uio_gpio_bank.md
Name: uio_gpio_bank

Overview:
- Parametrised general-purpose I/O bank for the tt10 bidirectional pin path.
- Generalises the fixed 8-bit uio_in/uio_out/uio_oe wiring:
  - configurable width and synchroniser depth
  - per-bit direction and output registers behind a small register port
  - input synchronisation
  - per-bit rising/falling edge capture with sticky status and a masked interrupt
- Sits between the top-level pin buses and the design's control logic.

Parameters:
- WIDTH, 8, number of I/O bits.
- SYNC_STAGES, 2, flops in each input synchroniser (legal range 2..4).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high; it is the only reset.
- pad_in  in  WIDTH  raw pin inputs (maps to uio_in).
- pad_out  out  WIDTH  pin output data (maps to uio_out).
- pad_oe  out  WIDTH  pin output enables, 1 = drive (maps to uio_oe).
- wr_en  in  1  register write strobe.
- rd_en  in  1  register read strobe.
- addr  in  3  register address, shared by read and write.
- wr_data  in  WIDTH  write data.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  high for one cycle when rd_data is valid.
- irq  out  1  OR of (STATUS & MASK).

Behaviour:
- Register map:
  - 0 DIR: RW, drives pad_oe.
  - 1 OUT: RW, drives pad_out.
  - 2 MASK: RW, interrupt enables.
  - 3 EDGE_SEL: RW, per bit 0 = rising, 1 = falling.
  - 4 STATUS: read; write-1-to-clear.
  - 5 PIN: RO, synchronised input value.
  - 6-7: unmapped. Writes are ignored; reads return 0 with rd_valid asserted.
- Reset (rst high at an edge):
  - All registers, synchroniser flops, previous-sample register and rd_data go to 0.
  - rd_valid = 0, irq = 0, pad_oe = 0 (all inputs), pad_out = 0.
  - Warm-up counter loads SYNC_STAGES+1.
- Reset mid-operation: the same applies on any cycle. Pending reads are discarded (no rd_valid on the following cycle).
- pad_oe and pad_out equal DIR and OUT directly, so they change the cycle after the write edge.
- Writes to RO or unmapped addresses have no effect.
- Read:
  - rd_en sampled at edge E gives rd_data/rd_valid updated at E.
  - They are visible in the cycle after the strobe, so latency is 1.
  - rd_valid deasserts the next cycle unless rd_en is held.
  - rd_data holds its last value when rd_valid = 0.
  - wr_en and rd_en may both be high: the read returns the pre-write value.
- Synchroniser:
  - pad_in passes through SYNC_STAGES flops to give sync.
  - prev is sync delayed one cycle.
  - PIN reads sync.
- Edge detect, for bit i:
  - rise = sync & ~prev; fall = ~sync & prev.
  - hit[i] = (EDGE_SEL[i] ? fall : rise) & ~DIR[i] & warm_done.
  - Output-configured bits never set status.
- Latency: a pad_in change set up before edge E0 sets STATUS at edge E0+SYNC_STAGES.
- Warm-up:
  - A down-counter from SYNC_STAGES+1 to 0 after reset.
  - warm_done = (counter == 0).
  - It suppresses spurious edges from pins already high at reset.
  - The counter saturates at 0.
- STATUS update: STATUS <= (STATUS & ~clear) | hit, where clear = wr_data when writing addr 4.
  - Set wins over clear on the same bit in the same cycle.
- irq:
  - Combinational from registers only: |(STATUS & MASK).
  - Glitch-free relative to clk.
  - Changing MASK affects irq in the next cycle.
- Changing EDGE_SEL or DIR takes effect for edges detected from the next cycle. Previously captured STATUS bits are kept.

Decomposition:
- Package uio_gpio_pkg holds:
  - address localparams: ADDR_DIR, ADDR_OUT, ADDR_MASK, ADDR_EDGE_SEL, ADDR_STATUS, ADDR_PIN
  - address width constant ADDR_W = 3
- One sub-module, uio_sync: a WIDTH×SYNC_STAGES synchroniser chain with synchronous active-high reset.
- Edge logic, registers and read mux stay in the top module.

Test Plan:
- Reset check: hold pad_in = 8'hFF through rst, release, wait 10 cycles.
  - pad_oe = 0, pad_out = 0, irq = 0.
  - STATUS read = 8'h00.
  - PIN read = 8'hFF.
- Register access: write DIR = 8'hF0, OUT = 8'hA5.
  - pad_oe = 8'hF0 and pad_out = 8'hA5 the next cycle.
  - Readback returns the same values with rd_valid one cycle after rd_en.
  - Read of addr 7 returns 8'h00 with rd_valid = 1.
- Rising edge: DIR = 0, MASK = 8'h01, pad_in[0] 0→1 before edge E0.
  - STATUS = 8'h01 at E0+2.
  - irq high from then.
  - W1C of 8'h01 drops irq the next cycle.
- Falling edge and masking: EDGE_SEL = 8'h02, MASK = 0, pad_in[1] 1→0.
  - STATUS = 8'h02, irq = 0.
  - Set MASK = 8'h02: irq = 1 the next cycle.
  - pad_in[1] 0→1: no new status.
- Set/clear collision: time W1C of 8'h04 to the same edge as a bit-2 rising hit.
  - STATUS[2] = 1 afterwards.
- Output-bit suppression plus mid-run reset:
  - DIR = 8'h08, toggle pad_in[3]: STATUS stays 0.
  - Assert rst during an rd_en: no rd_valid the following cycle, all registers at 0.
